dag_addr_gen: RTL and testbench

- Data address generator (DAG) sitting directly downstream of the program sequencer.
- Consumes the sequencer's DAG controls (ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy, ps_dg_iadd, ps_dg_madd) and its ureg read/write addresses.
- Holds eight I/M/L/B register sets and produces a data-memory address, or a jump/call target (dg_ps_add) back to the sequencer.
- Supports pre-modify, post-modify and circular buffering.

---
 rtl/dag_addr_gen.sv | 139 +++++++++++++
 tb/tb_dag_addr_gen.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dag_addr_gen.sv
// dag_addr_gen: data address generator that sits behind the program sequencer.
// It holds eight I/M/L/B register sets. Each op computes an effective address,
// with optional circular-buffer wrapping, and registers it either to the data
// memory bus or back to the sequencer as a jump/call target.
//
// Ports
//   clk, rst               clock; asynchronous active-low reset
//   ps_dg_en               perform a DAG op this cycle
//   ps_dg_dgsclt           1: result to dg_ps_add, 0: result to dg_dm_add
//   ps_dg_mdfy             1: pre-modify (I unchanged), 0: post-modify (I updated)
//   ps_dg_iadd/ps_dg_madd  I/L/B index and M index
//   ps_dg_wrt_en/_wrt_add  ureg write strobe and address ({group, index})
//   ps_dg_rd_add           ureg read address (same encoding)
//   bc_dt                  ureg write data
//   dg_ps_add, dg_dm_add   registered addresses
//   dg_bc_dt               combinational ureg read data
module dag_addr_gen #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps_dg_en,
    input  logic          ps_dg_dgsclt,
    input  logic          ps_dg_mdfy,
    input  logic [2:0]    ps_dg_iadd,
    input  logic [2:0]    ps_dg_madd,
    input  logic          ps_dg_wrt_en,
    input  logic [4:0]    ps_dg_wrt_add,
    input  logic [4:0]    ps_dg_rd_add,
    input  logic [DW-1:0] bc_dt,
    output logic [DW-1:0] dg_ps_add,
    output logic [DW-1:0] dg_dm_add,
    output logic [DW-1:0] dg_bc_dt
);

    localparam logic [1:0] GRP_I = 2'b00;
    localparam logic [1:0] GRP_M = 2'b01;
    localparam logic [1:0] GRP_L = 2'b10;
    localparam logic [1:0] GRP_B = 2'b11;

    logic [DW-1:0] i_q [8];
    logic [DW-1:0] i_d [8];
    logic [DW-1:0] m_q [8];
    logic [DW-1:0] m_d [8];
    logic [DW-1:0] l_q [8];
    logic [DW-1:0] l_d [8];
    logic [DW-1:0] b_q [8];
    logic [DW-1:0] b_d [8];
    logic [DW-1:0] ps_add_q, ps_add_d;
    logic [DW-1:0] dm_add_q, dm_add_d;

    // Address datapath: uses pre-edge register values only.
    logic [DW-1:0] cur_i, cur_m, cur_l, cur_b;
    logic [DW-1:0] sum, nxt, ea;
    logic [DW:0]   lim;
    logic          wrap_hi, wrap_lo;

    always_comb begin
        cur_i = i_q[ps_dg_iadd];
        cur_m = m_q[ps_dg_madd];
        cur_l = l_q[ps_dg_iadd];
        cur_b = b_q[ps_dg_iadd];
        sum   = cur_i + cur_m;
        // B+L is compared one bit wider so a buffer ending at the top of the
        // address space does not wrap to a small limit.
        lim     = {1'b0, cur_b} + {1'b0, cur_l};
        wrap_hi = (cur_l != '0) && !cur_m[DW-1] && ({1'b0, sum} >= lim);
        wrap_lo = (cur_l != '0) &&  cur_m[DW-1] && (sum < cur_b);
        nxt = sum;
        if (wrap_hi)      nxt = sum - cur_l;
        else if (wrap_lo) nxt = sum + cur_l;
        ea = ps_dg_mdfy ? nxt : cur_i;
    end

    always_comb begin
        i_d      = i_q;
        m_d      = m_q;
        l_d      = l_q;
        b_d      = b_q;
        ps_add_d = ps_add_q;
        dm_add_d = dm_add_q;
        if (ps_dg_en) begin
            if (ps_dg_dgsclt) ps_add_d = ea;
            else              dm_add_d = ea;
            if (!ps_dg_mdfy)  i_d[ps_dg_iadd] = nxt;
        end
        // Ureg writes come last so they override a same-edge post-modify.
        if (ps_dg_wrt_en) begin
            unique case (ps_dg_wrt_add[4:3])
                GRP_I: i_d[ps_dg_wrt_add[2:0]] = bc_dt;
                GRP_M: m_d[ps_dg_wrt_add[2:0]] = bc_dt;
                GRP_L: l_d[ps_dg_wrt_add[2:0]] = bc_dt;
                GRP_B: begin
                    b_d[ps_dg_wrt_add[2:0]] = bc_dt;
                    i_d[ps_dg_wrt_add[2:0]] = bc_dt;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < 8; j++) begin
                i_q[j] <= '0;
                m_q[j] <= '0;
                l_q[j] <= '0;
                b_q[j] <= '0;
            end
            ps_add_q <= '0;
            dm_add_q <= '0;
        end else begin
            i_q      <= i_d;
            m_q      <= m_d;
            l_q      <= l_d;
            b_q      <= b_d;
            ps_add_q <= ps_add_d;
            dm_add_q <= dm_add_d;
        end
    end

    // Ureg read with write-data bypass; post-modify results are not bypassed.
    always_comb begin
        dg_bc_dt = '0;
        if (ps_dg_wrt_en && (ps_dg_wrt_add == ps_dg_rd_add)) begin
            dg_bc_dt = bc_dt;
        end else begin
            unique case (ps_dg_rd_add[4:3])
                GRP_I: dg_bc_dt = i_q[ps_dg_rd_add[2:0]];
                GRP_M: dg_bc_dt = m_q[ps_dg_rd_add[2:0]];
                GRP_L: dg_bc_dt = l_q[ps_dg_rd_add[2:0]];
                GRP_B: dg_bc_dt = b_q[ps_dg_rd_add[2:0]];
            endcase
        end
    end

    assign dg_ps_add = ps_add_q;
    assign dg_dm_add = dm_add_q;

endmodule

// File: tb/tb_dag_addr_gen.sv
// Directed bench for dag_addr_gen; expected values are hand-computed.
module tb_dag_addr_gen;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ps_dg_en = 1'b0, ps_dg_dgsclt = 1'b0, ps_dg_mdfy = 1'b0;
    logic [2:0]    ps_dg_iadd = '0, ps_dg_madd = '0;
    logic          ps_dg_wrt_en = 1'b0;
    logic [4:0]    ps_dg_wrt_add = '0, ps_dg_rd_add = '0;
    logic [DW-1:0] bc_dt = '0;
    logic [DW-1:0] dg_ps_add, dg_dm_add, dg_bc_dt;

    int checks = 0;
    int errors = 0;

    dag_addr_gen #(.DW(DW)) dut (
        .clk(clk), .rst(rst),
        .ps_dg_en(ps_dg_en), .ps_dg_dgsclt(ps_dg_dgsclt), .ps_dg_mdfy(ps_dg_mdfy),
        .ps_dg_iadd(ps_dg_iadd), .ps_dg_madd(ps_dg_madd),
        .ps_dg_wrt_en(ps_dg_wrt_en), .ps_dg_wrt_add(ps_dg_wrt_add),
        .ps_dg_rd_add(ps_dg_rd_add), .bc_dt(bc_dt),
        .dg_ps_add(dg_ps_add), .dg_dm_add(dg_dm_add), .dg_bc_dt(dg_bc_dt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Ureg write on the next edge.
    task automatic wr(input logic [4:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        ps_dg_wrt_en = 1'b1; ps_dg_wrt_add = a; bc_dt = d;
        @(posedge clk); #1;
        ps_dg_wrt_en = 1'b0;
    endtask

    // Combinational ureg read (no write active).
    task automatic rd(input logic [4:0] a, output logic [DW-1:0] d);
        ps_dg_rd_add = a;
        #1 d = dg_bc_dt;
    endtask

    // One DAG op, optionally with a same-cycle ureg write.
    task automatic op(input logic sel, input logic mdfy, input logic [2:0] ia,
                      input logic [2:0] ma, input logic we, input logic [4:0] wa,
                      input logic [DW-1:0] wd);
        @(negedge clk);
        ps_dg_en = 1'b1; ps_dg_dgsclt = sel; ps_dg_mdfy = mdfy;
        ps_dg_iadd = ia; ps_dg_madd = ma;
        ps_dg_wrt_en = we; ps_dg_wrt_add = wa; bc_dt = wd;
        @(posedge clk); #1;
        ps_dg_en = 1'b0; ps_dg_wrt_en = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] v;
        #12 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_dm", dg_dm_add, 16'h0000);
        chk("rst_ps", dg_ps_add, 16'h0000);
        rd(5'b00000, v); chk("rst_I0", v, 16'h0000);

        // Linear post-modify
        wr(5'b00010, 16'h0100); wr(5'b01011, 16'h0004); wr(5'b10010, 16'h0000);
        op(0, 0, 2, 3, 0, 0, 0); chk("lin_ea0", dg_dm_add, 16'h0100);
        op(0, 0, 2, 3, 0, 0, 0); chk("lin_ea1", dg_dm_add, 16'h0104);
        rd(5'b00010, v); chk("lin_I2", v, 16'h0108);
        chk("lin_ps_hold", dg_ps_add, 16'h0000);

        // Circular wrap, positive modifier
        wr(5'b11001, 16'h0200);
        rd(5'b00001, v); chk("circ_I1_load", v, 16'h0200);
        wr(5'b10001, 16'h0006); wr(5'b01000, 16'h0004);
        op(0, 0, 1, 0, 0, 0, 0); chk("circ_ea0", dg_dm_add, 16'h0200);
        op(0, 0, 1, 0, 0, 0, 0); chk("circ_ea1", dg_dm_add, 16'h0204);
        op(0, 0, 1, 0, 0, 0, 0); chk("circ_ea2", dg_dm_add, 16'h0202);
        rd(5'b00001, v); chk("circ_I1", v, 16'h0200);
        // Negative modifier wraps up from below base
        wr(5'b01000, 16'hFFFC);
        op(0, 0, 1, 0, 0, 0, 0); chk("circn_ea", dg_dm_add, 16'h0200);
        rd(5'b00001, v); chk("circn_I1", v, 16'h0202);
        // Pre-modify uses the wrapped value: 0x202-4=0x1FE -> 0x204
        op(0, 1, 1, 0, 0, 0, 0); chk("circ_pre_ea", dg_dm_add, 16'h0204);
        rd(5'b00001, v); chk("circ_pre_I1", v, 16'h0202);

        // Pre-modify to PS
        wr(5'b00101, 16'h1000); wr(5'b01111, 16'h0010);
        op(1, 1, 5, 7, 0, 0, 0); chk("pre_ps", dg_ps_add, 16'h1010);
        rd(5'b00101, v); chk("pre_I5", v, 16'h1000);
        chk("pre_dm_hold", dg_dm_add, 16'h0204);

        // Idle cycle holds outputs
        @(posedge clk); #1;
        chk("idle_ps", dg_ps_add, 16'h1010);
        chk("idle_dm", dg_dm_add, 16'h0204);

        // Collision: ureg write to I4 wins over post-modify of I4
        wr(5'b00100, 16'h0010); wr(5'b01010, 16'h0001);
        op(0, 0, 4, 2, 1, 5'b00100, 16'hABCD);
        chk("col_ea", dg_dm_add, 16'h0010);
        rd(5'b00100, v); chk("col_I4", v, 16'hABCD);

        // Read bypass
        @(negedge clk);
        ps_dg_rd_add = 5'b01010; #1;
        chk("byp_off", dg_bc_dt, 16'h0001);
        ps_dg_wrt_en = 1'b1; ps_dg_wrt_add = 5'b01010; bc_dt = 16'h5555; #1;
        chk("byp_on", dg_bc_dt, 16'h5555);
        ps_dg_wrt_en = 1'b0;

        // Overflow wraps modulo 2^DW
        wr(5'b00000, 16'hFFFE); wr(5'b01001, 16'h0004); wr(5'b10000, 16'h0000);
        op(0, 0, 0, 1, 0, 0, 0); chk("ovf_ea", dg_dm_add, 16'hFFFE);
        rd(5'b00000, v); chk("ovf_I0", v, 16'h0002);

        // Asynchronous reset mid-cycle
        @(negedge clk); #2;
        rst = 1'b0; #1;
        chk("arst_dm", dg_dm_add, 16'h0000);
        chk("arst_ps", dg_ps_add, 16'h0000);
        rd(5'b00001, v); chk("arst_I1", v, 16'h0000);
        rd(5'b01000, v); chk("arst_M0", v, 16'h0000);
        rd(5'b10001, v); chk("arst_L1", v, 16'h0000);
        rd(5'b11001, v); chk("arst_B1", v, 16'h0000);
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
